// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: ALU/LSU result handshakes and the register-file write port
interface regfile_writeback_if #(
    parameter int XLEN = 32,
    parameter int REG_ADDR_W = 5
);
    logic alu_valid;
    logic alu_ready;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [XLEN-1:0] alu_data;
    logic lsu_valid;
    logic lsu_ready;
    logic [REG_ADDR_W-1:0] lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic wr_en;
    logic [REG_ADDR_W-1:0] wr_index;
    logic [XLEN-1:0] wr_data;
    modport master (
        output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        input  alu_ready, lsu_ready, wr_en, wr_index, wr_data
    );
    modport slave (
        input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
        output alu_ready, lsu_ready, wr_en, wr_index, wr_data
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: arbitrates ALU/LSU results onto the register file write port
module regfile_writeback #(
    parameter int XLEN = 32,
    parameter int REG_ADDR_W = 5,
    parameter int ALU_FIFO_DEPTH = 2,
    localparam int CW = $clog2(ALU_FIFO_DEPTH) + 1
) (
    input  logic clk,
    input  logic reset_n,
    regfile_writeback_if.slave bus,
    output logic [31:0] pending_mask,
    output logic [CW-1:0] fifo_count
);
    localparam int PW = ALU_FIFO_DEPTH > 1 ? $clog2(ALU_FIFO_DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(ALU_FIFO_DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(ALU_FIFO_DEPTH);

    logic up;
    logic [REG_ADDR_W-1:0] rd_mem [ALU_FIFO_DEPTH];
    logic [XLEN-1:0] data_mem [ALU_FIFO_DEPTH];
    logic [ALU_FIFO_DEPTH-1:0] vld;
    logic [PW-1:0] head, tail;
    logic alu_fire, lsu_fire, take_head, take_alu, push, sel;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0] sel_data;

    // up holds both readies low during reset and for the first edge after release
    assign bus.lsu_ready = up;
    assign bus.alu_ready = up && (fifo_count < FULL);
    assign alu_fire = bus.alu_valid && bus.alu_ready && (bus.alu_rd != '0);
    assign lsu_fire = bus.lsu_valid && bus.lsu_ready && (bus.lsu_rd != '0);
    assign take_head = !lsu_fire && (fifo_count != '0);
    assign take_alu = !lsu_fire && (fifo_count == '0) && alu_fire;
    assign push = alu_fire && !take_alu;
    assign sel = lsu_fire || take_head || take_alu;

    always_comb begin
        sel_rd = lsu_fire ? bus.lsu_rd : take_head ? rd_mem[head] : bus.alu_rd;
        sel_data = lsu_fire ? bus.lsu_data : take_head ? data_mem[head] : bus.alu_data;
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < ALU_FIFO_DEPTH; i++)
            if (vld[i]) pending_mask[rd_mem[i]] = 1'b1;
        if (bus.wr_en) pending_mask[bus.wr_index] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[tail] <= bus.alu_rd;
            data_mem[tail] <= bus.alu_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            up <= 1'b0;
            vld <= '0;
            head <= '0;
            tail <= '0;
            fifo_count <= '0;
            bus.wr_en <= 1'b0;
            bus.wr_index <= '0;
            bus.wr_data <= '0;
        end else begin
            up <= 1'b1;
            bus.wr_en <= sel;
            if (sel) begin
                bus.wr_index <= sel_rd;
                bus.wr_data <= sel_data;
            end
            if (push) begin
                vld[tail] <= 1'b1;
                tail <= tail == LAST ? '0 : tail + 1'b1;
            end
            if (take_head) begin
                vld[head] <= 1'b0;
                head <= head == LAST ? '0 : head + 1'b1;
            end
            fifo_count <= fifo_count + CW'(push) - CW'(take_head);
        end
    end
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed table, hand-written corner sequences and random traffic
// checked against a queue-based reference model of the writeback rules.
module tb_regfile_writeback;
    localparam int DEPTH = 2;
    logic clk = 1'b0;
    logic reset_n = 1'b1;
    logic [31:0] pending_mask;
    logic [1:0] fifo_count;
    int vectors = 0;
    int miscompares = 0;

    regfile_writeback_if #(.XLEN(32), .REG_ADDR_W(5)) bus ();
    regfile_writeback #(.XLEN(32), .REG_ADDR_W(5), .ALU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus),
        .pending_mask(pending_mask), .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0] rd;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic av;
        logic [4:0] ard;
        logic [31:0] ad;
        logic lv;
        logic [4:0] lrd;
        logic [31:0] ld;
        logic en;
        logic [4:0] idx;
        logic [31:0] data;
        logic [1:0] cnt;
        logic [31:0] pm;
    } vec_t;

    ent_t fifo_q[$];
    logic m_ready, m_en;
    logic [4:0] m_idx;
    logic [31:0] m_data;
    vec_t tbl[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = m_en ? (32'd1 << m_idx) : 32'd0;
        foreach (fifo_q[i]) p |= 32'd1 << fifo_q[i].rd;
        return p;
    endfunction

    task automatic model_reset();
        fifo_q.delete();
        m_ready = 1'b0;
        m_en = 1'b0;
        m_idx = '0;
        m_data = '0;
    endtask

    // one clock: drive, check combinational outputs, advance model and DUT, check port
    task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                         output logic acc);
        logic a_ok, l_ok, a_done;
        ent_t e;
        bus.alu_valid = av;
        bus.alu_rd = ard;
        bus.alu_data = ad;
        bus.lsu_valid = lv;
        bus.lsu_rd = lrd;
        bus.lsu_data = ld;
        #1;
        a_ok = m_ready && (fifo_q.size() < DEPTH);
        chk("alu_ready", bus.alu_ready, a_ok);
        chk("lsu_ready", bus.lsu_ready, m_ready);
        chk("pending_mask", pending_mask, m_pending());
        chk("fifo_count", fifo_count, fifo_q.size());
        acc = av && a_ok;
        l_ok = lv && m_ready && (lrd != 0);
        a_done = !(acc && ard != 0);
        m_en = 1'b1;
        if (l_ok) begin
            m_idx = lrd;
            m_data = ld;
        end else if (fifo_q.size() != 0) begin
            e = fifo_q.pop_front();
            m_idx = e.rd;
            m_data = e.data;
        end else if (!a_done) begin
            m_idx = ard;
            m_data = ad;
            a_done = 1'b1;
        end else m_en = 1'b0;
        if (!a_done) fifo_q.push_back({ard, ad});
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("wr_en", bus.wr_en, m_en);
        chk("wr_index", bus.wr_index, m_idx);
        chk("wr_data", bus.wr_data, m_data);
        if (bus.wr_en === 1'b1) chk("no_x0_write", bus.wr_index != 0, 1);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        chk({tag, "_wr_en"}, bus.wr_en, 0);
        chk({tag, "_fifo_count"}, fifo_count, 0);
        chk({tag, "_pending"}, pending_mask, 0);
        chk({tag, "_alu_ready"}, bus.alu_ready, 0);
        chk({tag, "_lsu_ready"}, bus.lsu_ready, 0);
        repeat (3) begin
            @(negedge clk);
            chk({tag, "_hold_wr_en"}, bus.wr_en, 0);
        end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
    endtask

    initial begin
        logic acc, a_pend;
        logic [4:0] a_rd;
        logic [31:0] a_data;
        tbl[0] = '{1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0, 32'h20};
        tbl[1] = '{0, 0, 0, 0, 0, 0, 0, 5, 32'hDEADBEEF, 0, 32'h0};
        tbl[2] = '{1, 3, 32'h11, 1, 4, 32'h22, 1, 4, 32'h22, 1, 32'h18};
        tbl[3] = '{0, 0, 0, 0, 0, 0, 1, 3, 32'h11, 0, 32'h08};
        tbl[4] = '{0, 0, 0, 0, 0, 0, 0, 3, 32'h11, 0, 32'h0};
        tbl[5] = '{1, 0, 32'h99, 0, 0, 0, 0, 3, 32'h11, 0, 32'h0};
        tbl[6] = '{1, 9, 32'hAB, 1, 7, 32'h77, 1, 7, 32'h77, 1, 32'h280};
        tbl[7] = '{0, 0, 0, 1, 0, 32'h55, 1, 9, 32'hAB, 0, 32'h200};
        tbl[8] = '{0, 0, 0, 0, 0, 0, 0, 9, 32'hAB, 0, 32'h0};
        model_reset();
        bus.alu_valid = 1'b1;
        bus.alu_rd = 5'd5;
        bus.alu_data = 32'h1;
        bus.lsu_valid = 1'b1;
        bus.lsu_rd = 5'd6;
        bus.lsu_data = 32'h2;
        #2;
        do_reset("rst");
        cycle(0, 0, 0, 0, 0, 0, acc);
        chk("rst_release_alu_ready", bus.alu_ready, 1);
        chk("rst_release_lsu_ready", bus.lsu_ready, 1);

        for (int i = 0; i < 9; i++) begin
            cycle(tbl[i].av, tbl[i].ard, tbl[i].ad, tbl[i].lv, tbl[i].lrd, tbl[i].ld, acc);
            chk("tbl_wr_en", bus.wr_en, tbl[i].en);
            chk("tbl_wr_index", bus.wr_index, tbl[i].idx);
            chk("tbl_wr_data", bus.wr_data, tbl[i].data);
            chk("tbl_fifo_count", fifo_count, tbl[i].cnt);
            chk("tbl_pending", pending_mask, tbl[i].pm);
        end

        // back-pressure: LSU hogs the port for 4 cycles while ALU offers x1..x3
        a_rd = 5'd1;
        for (int c = 0; c < 8; c++) begin
            cycle(a_rd <= 3, a_rd, 32'h100 + a_rd, c < 4, 5'd7, 32'h700 + c, acc);
            if (acc) a_rd++;
            if (c >= 1 && c <= 3) chk("bp_full_ready", bus.alu_ready, 0);
            if (c >= 4 && c <= 6) begin
                chk("bp_order_en", bus.wr_en, 1);
                chk("bp_order_index", bus.wr_index, c - 3);
            end
        end

        // asynchronous reset while the FIFO is full and a write is on the port
        cycle(1, 1, 32'hA1, 1, 7, 32'h71, acc);
        cycle(1, 2, 32'hA2, 1, 8, 32'h81, acc);
        chk("mid_pre_count", fifo_count, 2);
        chk("mid_pre_wr_en", bus.wr_en, 1);
        #2;
        bus.alu_valid = 1'b0;
        bus.lsu_valid = 1'b0;
        do_reset("mid");
        repeat (3) cycle(0, 0, 0, 0, 0, 0, acc);

        a_pend = 1'b0;
        a_rd = '0;
        a_data = '0;
        for (int n = 0; n < 400; n++) begin
            logic lv;
            logic [4:0] lrd;
            if (!a_pend && $urandom_range(0, 1) == 1) begin
                a_pend = 1'b1;
                a_rd = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
                a_data = $urandom;
            end
            lv = $urandom_range(0, 2) == 0;
            lrd = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom_range(1, 31));
            cycle(a_pend, a_rd, a_data, lv, lrd, $urandom, acc);
            if (acc) a_pend = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
